pe_ctx_seq: RTL and testbench

- Per-PE context sequencer that sits directly upstream of the PE register file.
- Holds a small context memory of per-cycle control words and, on start, replays them in order for a programmed number of iterations.
- Drives the 4-bit register-file select (R0..R3 load-vs-shift, bit3=R0 … bit0=R3) plus the full context word for the rest of the PE datapath.
- Supports stall and abort.

---
 rtl/pe_ctx_seq_pkg.sv | 16 +
 rtl/pe_ctx_seq_if.sv | 39 +++
 rtl/pe_ctx_mem.sv | 26 ++
 rtl/pe_ctx_seq.sv | 151 +++++++++++++++
 tb/tb_pe_ctx_seq.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ctx_seq_pkg.sv
// Shared definitions for the PE context sequencer: context word field layout,
// the idle register-file select and the sequencer state encoding.
package pe_ctx_seq_pkg;

    localparam int RF_SEL_LSB = 0;
    localparam int RF_SEL_W   = 4;

    localparam logic [RF_SEL_W-1:0] IDLE_INST_DEFAULT = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pe_ctx_seq_if.sv
// Configuration, control and issue bundle between a PE controller (master)
// and its context sequencer (slave).
interface pe_ctx_seq_if #(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_W     = 32,
    parameter int ITER_W    = 16
);
    import pe_ctx_seq_pkg::*;

    localparam int AW = $clog2(CTX_DEPTH);

    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [CTX_W-1:0]    cfg_wdata;
    logic                start;
    logic [AW-1:0]       ctx_last;
    logic [ITER_W-1:0]   iter_num;
    logic                stall;
    logic                abort;
    logic                busy;
    logic                ctx_valid;
    logic [CTX_W-1:0]    ctx_word;
    logic [RF_SEL_W-1:0] reg_file_inst;
    logic [AW-1:0]       ctx_idx;
    logic [ITER_W-1:0]   iter_cnt;
    logic                done;
    logic                cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, ctx_last, iter_num, stall, abort,
        input  busy, ctx_valid, ctx_word, reg_file_inst, ctx_idx, iter_cnt, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, ctx_last, iter_num, stall, abort,
        output busy, ctx_valid, ctx_word, reg_file_inst, ctx_idx, iter_cnt, done, cfg_err
    );

endinterface

// File: rtl/pe_ctx_mem.sv
// Context memory: one synchronous write port, one asynchronous read port so the
// sequencer can register the addressed word on the same edge it selects it.
module pe_ctx_mem #(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_W     = 32,
    localparam int AW       = $clog2(CTX_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CTX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CTX_W-1:0] rdata
);

    logic [CTX_W-1:0] mem [CTX_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer: replays context words 0..ctx_last for the latched
// number of iterations, with stall/abort, driving the register-file select.
module pe_ctx_seq
    import pe_ctx_seq_pkg::*;
#(
    parameter int                  CTX_DEPTH = 16,
    parameter int                  CTX_W     = 32,
    parameter int                  ITER_W    = 16,
    parameter logic [RF_SEL_W-1:0] IDLE_INST = IDLE_INST_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    pe_ctx_seq_if.slave bus
);

    localparam int AW = $clog2(CTX_DEPTH);

    seq_state_t          state_reg, state_next;
    logic [AW-1:0]       idx_reg, idx_next;
    logic [AW-1:0]       last_reg, last_next;
    logic [ITER_W-1:0]   iter_reg, iter_next;
    logic [ITER_W-1:0]   iter_last_reg, iter_last_next;
    logic                valid_reg, valid_next;
    logic                busy_reg;
    logic                done_reg, done_next;
    logic                cfg_err_reg, cfg_err_next;
    logic [CTX_W-1:0]    word_reg, word_next;
    logic [RF_SEL_W-1:0] inst_reg, inst_next;
    logic [CTX_W-1:0]    rd_data, issue_word;
    logic                mem_we, more_ctx, more_iter;

    assign mem_we    = bus.cfg_we && (state_reg == ST_IDLE);
    assign more_ctx  = idx_reg < last_reg;
    assign more_iter = iter_reg < iter_last_reg;

    pe_ctx_mem #(
        .CTX_DEPTH (CTX_DEPTH),
        .CTX_W     (CTX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_wdata),
        .raddr (idx_next),
        .rdata (rd_data)
    );

    // A write landing on the same edge as the issue must be seen by that issue.
    assign issue_word = (mem_we && (bus.cfg_addr == idx_next)) ? bus.cfg_wdata : rd_data;
    assign word_next  = valid_next ? issue_word : word_reg;
    assign inst_next  = valid_next ? issue_word[RF_SEL_LSB +: RF_SEL_W] : IDLE_INST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (!bus.stall && !more_ctx && !more_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_next       = idx_reg;
        iter_next      = iter_reg;
        last_next      = last_reg;
        iter_last_next = iter_last_reg;
        valid_next     = 1'b0;
        cfg_err_next   = bus.cfg_we && (state_reg != ST_IDLE);
        done_next      = (state_reg == ST_RUN) && (state_next == ST_DONE);
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    last_next      = bus.ctx_last;
                    // Zero iterations behaves as one; store the last 0-based iteration.
                    iter_last_next = (bus.iter_num == '0) ? '0 : bus.iter_num - 1'b1;
                    idx_next       = '0;
                    iter_next      = '0;
                    valid_next     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.abort && !bus.stall) begin
                    if (more_ctx) begin
                        idx_next   = idx_reg + 1'b1;
                        valid_next = 1'b1;
                    end else if (more_iter) begin
                        idx_next   = '0;
                        iter_next  = iter_reg + 1'b1;
                        valid_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_reg       <= '0;
            iter_reg      <= '0;
            last_reg      <= '0;
            iter_last_reg <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
            word_reg      <= '0;
            inst_reg      <= IDLE_INST;
        end else begin
            idx_reg       <= idx_next;
            iter_reg      <= iter_next;
            last_reg      <= last_next;
            iter_last_reg <= iter_last_next;
            valid_reg     <= valid_next;
            busy_reg      <= (state_next == ST_RUN);
            done_reg      <= done_next;
            cfg_err_reg   <= cfg_err_next;
            word_reg      <= word_next;
            inst_reg      <= inst_next;
        end
    end

    assign bus.busy          = busy_reg;
    assign bus.ctx_valid     = valid_reg;
    assign bus.ctx_word      = word_reg;
    assign bus.reg_file_inst = inst_reg;
    assign bus.ctx_idx       = idx_reg;
    assign bus.iter_cnt      = iter_reg;
    assign bus.done          = done_reg;
    assign bus.cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Scoreboard bench for pe_ctx_seq: the driver queues every context issue a run
// should produce; a monitor pops and compares on each valid output cycle.
module tb_pe_ctx_seq;
    import pe_ctx_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int W     = 32;
    localparam int IW    = 16;

    typedef struct {
        logic [W-1:0] word;
        int           idx;
        int           iter;
        bit           final_e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_ctx_seq_if #(.CTX_DEPTH(DEPTH), .CTX_W(W), .ITER_W(IW)) bus ();

    pe_ctx_seq #(
        .CTX_DEPTH (DEPTH),
        .CTX_W     (W),
        .ITER_W    (IW),
        .IDLE_INST (IDLE_INST_DEFAULT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem_model [DEPTH];
    exp_t         q [$];
    exp_t         mon_e;
    int           vectors    = 0;
    int           miscompares = 0;
    int           done_cnt   = 0;
    int           exp_done   = 0;
    bit           final_seen = 0;

    logic [3:0] nibs [3]     = '{4'h8, 4'h4, 4'hF};
    int         sv_valid [6] = '{1, 0, 0, 1, 1, 0};
    int         sv_idx [6]   = '{0, 0, 0, 1, 2, 2};
    int         sv_done [6]  = '{0, 0, 0, 0, 0, 1};

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(int addr, logic [W-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'(addr);
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
        mem_model[addr] = d;
    endtask

    // Reference: a run issues words 0..last in order, once per iteration.
    task automatic push_run(int last, int iters);
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i <= last; i++) begin
                exp_t e;
                e.word    = mem_model[i];
                e.idx     = i;
                e.iter    = it;
                e.final_e = (it == iters - 1) && (i == last);
                q.push_back(e);
            end
        end
    endtask

    task automatic start_run(int last, int n, bit wr0, logic [W-1:0] d0);
        bus.start    = 1'b1;
        bus.ctx_last = 4'(last);
        bus.iter_num = 16'(n);
        if (wr0) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = '0;
            bus.cfg_wdata = d0;
            mem_model[0]  = d0;
        end
        push_run(last, (n == 0) ? 1 : n);
        exp_done++;
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic cancel_run();
        q.delete();
        exp_done--;
        final_seen = 0;
    endtask

    task automatic run_wait(int abort_at, int stall_pct);
        bit fin;
        fin = 0;
        for (int c = 1; c < 3000; c++) begin
            bus.stall = ($urandom_range(0, 99) < stall_pct);
            bus.abort = (c == abort_at);
            tick();
            if (c == abort_at) begin
                bus.abort = 1'b0;
                cancel_run();
                fin = 1;
                break;
            end
            if (done_cnt == exp_done && q.size() == 0) begin
                fin = 1;
                break;
            end
        end
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        check("run_completes", fin, 1);
    endtask

    // Monitor: every output cycle is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ctx_valid) begin
                check("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("mon_word", bus.ctx_word, mon_e.word);
                    check("mon_rf_inst", bus.reg_file_inst, mon_e.word[3:0]);
                    check("mon_idx", bus.ctx_idx, mon_e.idx);
                    check("mon_iter", bus.iter_cnt, mon_e.iter);
                    check("mon_busy", bus.busy, 1);
                    if (mon_e.final_e) final_seen = 1;
                end
            end else begin
                check("mon_idle_inst", bus.reg_file_inst, IDLE_INST_DEFAULT);
            end
            if (bus.done) begin
                done_cnt++;
                check("done_after_final", final_seen, 1);
                check("done_busy", bus.busy, 0);
                final_seen = 0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, n, iters, total, ab, nw;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.start = 0;
        bus.ctx_last = '0; bus.iter_num = '0; bus.stall = 0; bus.abort = 0;

        // Reset values
        tick(); tick(); tick();
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.ctx_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_word", bus.ctx_word, 0);
        check("rst_rf_inst", bus.reg_file_inst, IDLE_INST_DEFAULT);
        check("rst_idx", bus.ctx_idx, 0);
        check("rst_iter", bus.iter_cnt, 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) do_write(i, $urandom);
        do_write(0, 32'hA5A5_0008);
        do_write(1, 32'h1234_5674);
        do_write(2, 32'hDEAD_BEEF);

        // Reset mid-run, memory retained
        start_run(2, 1, 0, '0);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cancel_run();
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.ctx_valid, 0);
        check("midrst_word", bus.ctx_word, 0);
        check("midrst_idx", bus.ctx_idx, 0);
        check("midrst_iter", bus.iter_cnt, 0);
        check("midrst_rf_inst", bus.reg_file_inst, IDLE_INST_DEFAULT);
        tick();
        start_run(2, 1, 0, '0);
        run_wait(0, 0);

        // Basic replay with exact cycle timing
        start_run(2, 2, 0, '0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 6) begin
                check("basic_valid", bus.ctx_valid, 1);
                check("basic_idx", bus.ctx_idx, (c - 1) % 3);
                check("basic_iter", bus.iter_cnt, (c - 1) / 3);
                check("basic_rf_inst", bus.reg_file_inst, nibs[(c - 1) % 3]);
                check("basic_busy", bus.busy, 1);
            end else begin
                check("basic_done", bus.done, 1);
                check("basic_busy_low", bus.busy, 0);
                check("basic_valid_low", bus.ctx_valid, 0);
            end
            tick();
        end

        // Stall on cycles 2-3
        start_run(2, 1, 0, '0);
        for (int c = 1; c <= 6; c++) begin
            bus.stall = (c == 1 || c == 2);
            @(negedge clk);
            check("stall_valid", bus.ctx_valid, sv_valid[c - 1]);
            check("stall_idx", bus.ctx_idx, sv_idx[c - 1]);
            check("stall_done", bus.done, sv_done[c - 1]);
            if (c == 2 || c == 3) check("stall_word_hold", bus.ctx_word, mem_model[0]);
            tick();
        end
        bus.stall = 1'b0;

        // Abort (with simultaneous stall) on the 2nd valid cycle
        start_run(2, 2, 0, '0);
        tick();
        bus.abort = 1'b1;
        bus.stall = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        cancel_run();
        @(negedge clk);
        check("abort_valid", bus.ctx_valid, 0);
        check("abort_busy", bus.busy, 0);
        tick(); tick(); tick();
        start_run(2, 1, 0, '0);
        run_wait(0, 0);

        // iter_num=0, ctx_last=0: single valid cycle
        start_run(0, 0, 0, '0);
        @(negedge clk);
        check("it0_valid", bus.ctx_valid, 1);
        tick();
        @(negedge clk);
        check("it0_valid_end", bus.ctx_valid, 0);
        check("it0_done", bus.done, 1);
        tick();

        // Config lockout and start during RUN
        start_run(2, 3, 0, '0);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'd1;
        bus.cfg_wdata = ~mem_model[1];
        bus.start     = 1'b1;
        bus.ctx_last  = 4'd0;
        bus.iter_num  = 16'd1;
        tick();
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        check("lock_cfg_err", bus.cfg_err, 1);
        tick();
        @(negedge clk);
        check("lock_cfg_err_pulse", bus.cfg_err, 0);
        tick();
        run_wait(0, 0);

        // Write to address 0 on the start cycle, then full-depth replay
        start_run(3, 2, 1, 32'hCAFE_0009);
        run_wait(0, 0);
        start_run(DEPTH - 1, 2, 0, '0);
        run_wait(0, 20);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) do_write($urandom_range(0, DEPTH - 1), $urandom);
            last  = $urandom_range(0, DEPTH - 1);
            n     = $urandom_range(0, 4);
            iters = (n == 0) ? 1 : n;
            total = (last + 1) * iters;
            ab    = ($urandom_range(0, 99) < 15) ? $urandom_range(1, total) : 0;
            start_run(last, n, ($urandom_range(0, 3) == 0), $urandom);
            run_wait(ab, 30);
        end

        tick(); tick();
        check("done_count", done_cnt, exp_done);
        check("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
